ps2_key_scheduler: RTL

//  Receives PS/2 keyboard frames, decodes make/break/extended scan-code sequences and

---
 rtl/ps2_pkg.sv | 56 +++++
 rtl/ps2_frame_rx.sv | 126 ++++++++++++
 rtl/ps2_key_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 ball-control front end:
// command opcodes, scan codes, frame receiver states and the key lookup.
package ps2_pkg;

    localparam logic [2:0] OP_YINC   = 3'd0;
    localparam logic [2:0] OP_YDEC   = 3'd1;
    localparam logic [2:0] OP_XDEC   = 3'd2;
    localparam logic [2:0] OP_XINC   = 3'd3;
    localparam logic [2:0] OP_SEL1   = 3'd4;
    localparam logic [2:0] OP_SEL2   = 3'd5;
    localparam logic [2:0] OP_SEL3   = 3'd6;
    localparam logic [2:0] OP_COMMIT = 3'd7;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_KEY1  = 8'h16;
    localparam logic [7:0] SC_KEY2  = 8'h1E;
    localparam logic [7:0] SC_KEY3  = 8'h26;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] op;
    } key_cmd_t;

    // Keypad and extended arrows share codes, so the E0 prefix never reaches this table.
    function automatic key_cmd_t lookup_key(input logic [7:0] code);
        key_cmd_t r;
        r.hit = 1'b1;
        r.op  = OP_YINC;
        case (code)
            SC_UP:    r.op = OP_YINC;
            SC_DOWN:  r.op = OP_YDEC;
            SC_LEFT:  r.op = OP_XDEC;
            SC_RIGHT: r.op = OP_XINC;
            SC_KEY1:  r.op = OP_SEL1;
            SC_KEY2:  r.op = OP_SEL2;
            SC_KEY3:  r.op = OP_SEL3;
            SC_ENTER: r.op = OP_COMMIT;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// start/data/parity/stop framing and a mid-frame stall timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]   clk_sync;
    logic [1:0]   data_sync;
    logic         clk_prev;
    logic         fall;
    logic         bit_in;

    frame_state_t state;
    frame_state_t state_nxt;
    logic [7:0]   shift;
    logic [2:0]   bit_cnt;
    logic         ones_odd;
    logic [TW-1:0] tmo_cnt;
    logic         timeout_hit;
    logic         stb_nxt;
    logic         err_nxt;

    // Idle-high reset values keep reset release from looking like a clock edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking here so every flop samples the previous cycle's value;
            // blocking would collapse the two-stage synchroniser into one.
            clk_sync  <= {clk_sync[0], PS2_CLK};
            data_sync <= {data_sync[0], PS2_DATA};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall        = clk_prev & ~clk_sync[1];
    assign bit_in      = data_sync[1];
    assign timeout_hit = (state != ST_IDLE) && !fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps paths without an
        // assignment from inferring a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fall && !bit_in)            state_nxt = ST_DATA;
            ST_DATA:   if (fall && bit_cnt == 3'd7)    state_nxt = ST_PARITY;
            ST_PARITY: if (fall)                       state_nxt = ST_STOP;
            ST_STOP:   if (fall)                       state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) state_nxt = ST_IDLE;
    end

    always_comb begin
        stb_nxt = 1'b0;
        err_nxt = 1'b0;
        case (state)
            ST_IDLE: err_nxt = fall && bit_in;
            ST_STOP: begin
                if (fall) begin
                    stb_nxt = bit_in && ones_odd;
                    err_nxt = !(bit_in && ones_odd);
                end
            end
            default: ;
        endcase
        if (timeout_hit) err_nxt = 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            ones_odd  <= 1'b0;
            tmo_cnt   <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= stb_nxt;
            frame_err <= err_nxt;

            if (fall || timeout_hit)  tmo_cnt <= '0;
            else if (state != ST_IDLE) tmo_cnt <= tmo_cnt + 1'b1;

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt  <= '0;
                        ones_odd <= 1'b0;
                    end
                    ST_DATA: begin
                        shift    <= {bit_in, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        ones_odd <= ones_odd ^ bit_in;
                    end
                    ST_PARITY: ones_odd <= ones_odd ^ bit_in;
                    default: ;
                endcase
            end
        end
    end

    // Shift register holds the byte untouched until the next frame's first data bit.
    assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_scheduler.sv
// PS/2 keyboard to ball-control command scheduler: frame receiver, break-code
// decoder and a small circular command queue with a valid/ready output.
module ps2_key_scheduler
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         PS2_CLK,
    input  logic                         PS2_DATA,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [2:0]                   cmd_op,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_err,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]  rx_byte;
    logic        byte_stb;
    key_cmd_t    key;
    logic        brk;
    logic        push_vld;
    logic [2:0]  push_op;

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .CLK       (CLK),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb),
        .frame_err (frame_err)
    );

    assign key = lookup_key(rx_byte);

    // E0 only marks extended keys, which map exactly like their keypad twins, so it
    // needs no state of its own: it is consumed and leaves the break flag alone.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            brk      <= 1'b0;
            push_vld <= 1'b0;
            push_op  <= OP_YINC;
        end else begin
            push_vld <= 1'b0;
            if (byte_stb) begin
                if (rx_byte == SC_F0) begin
                    brk <= 1'b1;
                end else if (rx_byte != SC_E0) begin
                    push_vld <= brk && key.hit;
                    push_op  <= key.op;
                    brk      <= 1'b0;
                end
            end
        end
    end

    assign cmd_valid  = (count != '0);
    assign full       = (count == FULL_CNT);
    assign pop        = cmd_valid && cmd_ready;
    assign push_ok    = push_vld && (!full || pop);
    assign cmd_op     = cmd_valid ? mem[rd_ptr] : OP_YINC;
    assign fifo_count = count;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            // NOTE: the queue storage is cleared too, so nothing stale can ever be
            // presented on cmd_op after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_vld && full && !pop;
            if (push_ok) begin
                mem[wr_ptr] <= push_op;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
